hps_fpga_pio_strobe: RTL
========================

Name: hps_fpga_pio_strobe

Overview:
- Parametrised Avalon-MM slave output port for the HPS-to-FPGA bridge.
- Replaces the single-bit, software-toggled FIFO clock PIO with two outputs:
  - a DATA_WIDTH-bit output register with atomic bit set and bit clear;
  - a hardware strobe generator that emits a programmed burst of N pulses at a programmable half-period, so software no longer bit-bangs the FIFO clock.
- Sits between the HPS lightweight bridge and FPGA-side FIFO/control logic.

Parameters:
- DATA_WIDTH, 8, width of out_port (1..32).
- CNT_WIDTH, 16, width of the divider and burst counters (1..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero read latency.
- out_port  out  DATA_WIDTH  general output register.
- strobe_out  out  1  generated pulse train.
- busy  out  1  burst in progress.
- irq  out  1  interrupt (present only with the optional feature).

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: out_port=0, strobe_out=0, busy=0, DIV=0, remaining=0, done=0, overrun=0, irq=0, state=IDLE.
- Write qualifier: wr = chipselect & ~write_n. Register updates take effect on the clk edge that samples wr.
- Register map. Unused upper bits read 0; writes to unmapped addresses are ignored.
  - 0 DATA (rw): out_port <= writedata[DATA_WIDTH-1:0].
  - 1 SET (wo, reads 0): out_port <= out_port | writedata.
  - 2 CLR (wo, reads 0): out_port <= out_port & ~writedata.
  - 3 DIV (rw): half-period minus 1. Each phase lasts DIV+1 clk cycles.
  - 4 BURST (wo): starts a burst. Reads return the remaining pulse count.
  - 5 STATUS (r/w1c): bit0 busy (write 1 = abort), bit1 done (write 1 = clear), bit2 overrun (write 1 = clear).
  - 6 IRQ_MASK: only with the optional feature, otherwise reads 0.
- readdata is a mux of address with no chipselect gating, matching the existing PIO slaves.
- Strobe FSM, states IDLE, HIGH, LOW:
  - IDLE + BURST write with N≠0: strobe_out<=1, cnt<=DIV, remaining<=N, go to HIGH. A write with N=0 is ignored (no state change, no done).
  - HIGH: if cnt==0, strobe_out<=0, cnt<=DIV, go to LOW; else cnt--.
  - LOW: if cnt==0 and remaining==1, remaining<=0, done<=1, go to IDLE. If cnt==0 otherwise, remaining--, strobe_out<=1, cnt<=DIV, go to HIGH. Else cnt--.
  - Total burst length = 2·N·(DIV+1) cycles from the start edge to the done edge.
- busy = (state≠IDLE).
- BURST write while busy: ignored, overrun<=1. The running burst is unaffected.
- DIV write during a burst: takes effect at the next phase reload. The current phase is not shortened.
- Abort (STATUS bit0 write 1 while busy): state<=IDLE, strobe_out<=0, remaining<=0, done unchanged. Abort while IDLE has no effect.
- Simultaneous events:
  - The done-setting edge and a STATUS write-1 to bit1 in the same cycle: set wins, done=1.
  - Abort and the natural burst end in the same cycle: abort wins, done not set.
- Counter width: BURST and DIV are truncated to CNT_WIDTH bits. Maximum burst is 2^CNT_WIDTH−1 pulses. No wrap: remaining never decrements below 1 inside the FSM.
- Reset mid-burst: all state returns to reset values on the next edge, strobe_out goes low immediately after that edge.

Optional Feature:
- Macro: PIO_STROBE_IRQ_EN.
- Defined:
  - Adds the irq port and IRQ_MASK at address 6 (rw, bit0 = done enable, bit1 = overrun enable, reset 0).
  - irq = (done & mask[0]) | (overrun & mask[1]), registered, asserted one cycle after the source flag sets.
  - Cleared by the STATUS w1c.
- Undefined:
  - No irq port.
  - Address 6 reads 0 and ignores writes.
  - Identical behaviour otherwise.

Test Plan:
- Reset → write DATA=0xA5 → out_port=0xA5. SET 0x0F → 0xAF. CLR 0xA0 → 0x0F. Reads of addr 0 return 0x0F; reads of addr 1 and 2 return 0.
- DIV=1, BURST=3 → strobe_out pattern 1,1,0,0 repeated ×3. busy high exactly 12 cycles. done=1 on the 12th edge. STATUS reads 0x2. Write STATUS=0x2 → reads 0x0.
- DIV=0, BURST=0 → no activity, busy stays 0, done stays 0. Then BURST=1 → exactly one high cycle followed by one low cycle.
- DIV=3, BURST=5; after 2 pulses write BURST=7 → ignored, overrun=1, total pulse count still 5. Then write STATUS=0x1 mid-pulse → strobe_out=0 next cycle, busy=0, done=0.
- DIV=2, BURST=4; assert reset for 1 cycle mid-HIGH → strobe_out=0, busy=0, readdata for addr 3 = 0, out_port=0 after that edge.
- With PIO_STROBE_IRQ_EN: IRQ_MASK=0x1, BURST=2, DIV=0 → irq rises one cycle after done sets and falls after STATUS=0x2. With IRQ_MASK=0 → irq stays 0.

Source files
------------

// File: rtl/hps_fpga_pio_strobe.sv
// hps_fpga_pio_strobe
//
// Avalon-MM slave output port for the HPS-to-FPGA lightweight bridge. It provides
// a general output register with atomic bit set/clear, and a strobe generator.
// The generator emits a programmed burst of N pulses, each phase lasting DIV+1
// clocks, so software no longer has to bit-bang the FIFO clock.
//
// Optional feature: define PIO_STROBE_IRQ_EN to add the irq port and the IRQ_MASK
// register at address 6. Without it, address 6 reads 0 and ignores writes.
//
// Ports:
//   clk         system clock
//   reset       synchronous reset, active-high
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational, zero read latency
//   out_port    general output register
//   strobe_out  generated pulse train
//   busy        burst in progress
//   irq         interrupt (PIO_STROBE_IRQ_EN only)
//
// Register map:
//   0 DATA    rw   output register
//   1 SET     wo   out_port |= writedata
//   2 CLR     wo   out_port &= ~writedata
//   3 DIV     rw   phase length minus 1
//   4 BURST   w: start burst of N pulses, r: remaining pulse count
//   5 STATUS  bit0 busy (w1 = abort), bit1 done (w1c), bit2 overrun (w1c)
//   6 IRQ_MASK rw  bit0 done enable, bit1 overrun enable (optional)

module hps_fpga_pio_strobe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  strobe_out,
  output logic                  busy
`ifdef PIO_STROBE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrSet    = 3'd1;
  localparam logic [2:0] AddrClr    = 3'd2;
  localparam logic [2:0] AddrDiv    = 3'd3;
  localparam logic [2:0] AddrBurst  = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;
`ifdef PIO_STROBE_IRQ_EN
  localparam logic [2:0] AddrMask   = 3'd6;
`endif

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [CNT_WIDTH-1:0]  div_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic                  strobe_q;
  logic                  done_q;
  logic                  overrun_q;
`ifdef PIO_STROBE_IRQ_EN
  logic [1:0]            mask_q;
  logic                  irq_q;
`endif

  logic                  wr;
  logic                  wr_burst;
  logic                  wr_status;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  burst_n;
  logic                  unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_burst  = wr && (address == AddrBurst);
  assign wr_status = wr && (address == AddrStatus);
  assign burst_n   = writedata[CNT_WIDTH-1:0];
  // Abort only acts on a running burst; while idle the bit is a no-op.
  assign abort     = wr_status && writedata[0] && (state_q != StIdle);
  // Upper write-data bits are legitimately ignored for narrow configurations.
  assign unused_wdata = ^writedata;

  assign out_port   = out_q;
  assign strobe_out = strobe_q;
  assign busy       = (state_q != StIdle);
`ifdef PIO_STROBE_IRQ_EN
  assign irq        = irq_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PIO_STROBE_IRQ_EN
      mask_q      <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      if (wr) begin
        case (address)
          AddrData: out_q <= writedata[DATA_WIDTH-1:0];
          AddrSet:  out_q <= out_q | writedata[DATA_WIDTH-1:0];
          AddrClr:  out_q <= out_q & ~writedata[DATA_WIDTH-1:0];
          AddrDiv:  div_q <= writedata[CNT_WIDTH-1:0];
`ifdef PIO_STROBE_IRQ_EN
          AddrMask: mask_q <= writedata[1:0];
`endif
          default: ;
        endcase
      end

      // Flag clears come first so that a same-cycle set from the FSM wins.
      if (wr_status && writedata[1]) done_q    <= 1'b0;
      if (wr_status && writedata[2]) overrun_q <= 1'b0;
      if (wr_burst && (state_q != StIdle)) overrun_q <= 1'b1;

`ifdef PIO_STROBE_IRQ_EN
      // Registered from the flags, so irq follows a flag by one cycle.
      irq_q <= (done_q & mask_q[0]) | (overrun_q & mask_q[1]);
`endif

      if (abort) begin
        // Abort beats a natural end in the same cycle: done is not set.
        state_q     <= StIdle;
        strobe_q    <= 1'b0;
        remaining_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (wr_burst && (burst_n != '0)) begin
              strobe_q    <= 1'b1;
              cnt_q       <= div_q;
              remaining_q <= burst_n;
              state_q     <= StHigh;
            end
          end
          StHigh: begin
            if (cnt_q == '0) begin
              strobe_q <= 1'b0;
              cnt_q    <= div_q;
              state_q  <= StLow;
            end else begin
              cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
          end
          StLow: begin
            if (cnt_q == '0) begin
              if (remaining_q == CNT_WIDTH'(1)) begin
                remaining_q <= '0;
                done_q      <= 1'b1;
                state_q     <= StIdle;
              end else begin
                remaining_q <= remaining_q - CNT_WIDTH'(1);
                strobe_q    <= 1'b1;
                cnt_q       <= div_q;
                state_q     <= StHigh;
              end
            end else begin
              cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // No chipselect gating on reads, matching the existing PIO slaves.
  always_comb begin
    readdata = '0;
    case (address)
      AddrData:   readdata[DATA_WIDTH-1:0] = out_q;
      AddrDiv:    readdata[CNT_WIDTH-1:0]  = div_q;
      AddrBurst:  readdata[CNT_WIDTH-1:0]  = remaining_q;
      AddrStatus: readdata[2:0]            = {overrun_q, done_q, busy};
`ifdef PIO_STROBE_IRQ_EN
      AddrMask:   readdata[1:0]            = mask_q;
`endif
      default: ;
    endcase
  end

endmodule
